ped_crossing_requester: RTL and testbench



---
 rtl/ped_crossing_requester_pkg.sv | 22 ++
 rtl/ped_crossing_requester_if.sv | 33 +++
 rtl/ped_crossing_requester_btn_debouncer.sv | 51 +++++
 rtl/ped_crossing_requester.sv | 169 ++++++++++++++++
 tb/tb_ped_crossing_requester.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/ped_crossing_requester_pkg.sv
// Shared definitions for the pedestrian crossing requester.
//   ped_state_t          : crossing FSM states
//   DEF_* timing values  : default cycle counts, also used by the light controller bench
package ped_crossing_requester_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQUEST,
        WALK,
        FLASH,
        CLEAR,
        LOCKOUT
    } ped_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_WALK_CYCLES     = 8;
    localparam int DEF_FLASH_CYCLES    = 6;
    localparam int DEF_FLASH_HALF      = 2;
    localparam int DEF_LOCKOUT_CYCLES  = 5;
    localparam int DEF_CNT_W           = 8;

endpackage

// File: rtl/ped_crossing_requester_if.sv
// Panel <-> controller signal bundle for the pedestrian crossing requester.
//   btn_raw                      : raw push-button (asynchronous)
//   light_red/yellow/green       : controller lamp outputs
//   ped_request                  : request to controller pedestrian_button
//   walk, dont_walk, countdown   : pedestrian lamps and display
//   req_pending, fault           : status
// Modports: master = panel/controller side, slave = requester block.
interface ped_crossing_requester_if
    import ped_crossing_requester_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             btn_raw;
    logic             light_red;
    logic             light_yellow;
    logic             light_green;
    logic             ped_request;
    logic             walk;
    logic             dont_walk;
    logic [CNT_W-1:0] countdown;
    logic             req_pending;
    logic             fault;

    modport master (
        output btn_raw, light_red, light_yellow, light_green,
        input  ped_request, walk, dont_walk, countdown, req_pending, fault
    );

    modport slave (
        input  btn_raw, light_red, light_yellow, light_green,
        output ped_request, walk, dont_walk, countdown, req_pending, fault
    );
endinterface

// File: rtl/ped_crossing_requester_btn_debouncer.sv
// Button conditioner: 2-flop synchroniser, debounce counter, rising-edge pulse.
//   clk, rst : clock, synchronous active-high reset
//   din      : asynchronous input
//   level    : debounced level
//   rise     : one-cycle pulse, registered together with a 0->1 change of level
module btn_debouncer
    import ped_crossing_requester_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2 ** CNT_W)) begin : g_bad_debounce
        $error("btn_debouncer: DEBOUNCE_CYCLES out of range for CNT_W");
    end

    logic             sync_q1, sync_q2;
    logic [CNT_W-1:0] stab_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1  <= 1'b0;
            sync_q2  <= 1'b0;
            stab_cnt <= '0;
            level    <= 1'b0;
            rise     <= 1'b0;
        end else begin
            sync_q1 <= din;
            sync_q2 <= sync_q1;
            rise    <= 1'b0;
            // stab_cnt counts consecutive cycles the synchronised input
            // disagrees with the accepted level; any agreement restarts it.
            if (sync_q2 == level) begin
                stab_cnt <= '0;
            end else if (stab_cnt >= LAST) begin
                level    <= sync_q2;
                rise     <= sync_q2;
                stab_cnt <= '0;
            end else begin
                stab_cnt <= stab_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/ped_crossing_requester.sv
// Pedestrian-side requester: conditions the push-button, latches a request,
// holds ped_request to the light controller while people cross, and drives
// WALK / DONT_WALK lamps and the crossing countdown. All outputs registered.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave modport of ped_crossing_requester_if
module ped_crossing_requester
    import ped_crossing_requester_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int WALK_CYCLES     = DEF_WALK_CYCLES,
    parameter int FLASH_CYCLES    = DEF_FLASH_CYCLES,
    parameter int FLASH_HALF      = DEF_FLASH_HALF,
    parameter int LOCKOUT_CYCLES  = DEF_LOCKOUT_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    ped_crossing_requester_if.slave bus
);
    if (WALK_CYCLES + FLASH_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_cnt_w
        $error("ped_crossing_requester: WALK_CYCLES+FLASH_CYCLES does not fit in CNT_W");
    end

    localparam logic [CNT_W-1:0] CROSS_LOAD = CNT_W'(WALK_CYCLES + FLASH_CYCLES);
    localparam logic [CNT_W-1:0] FLASH_LD   = CNT_W'(FLASH_CYCLES);
    localparam logic [CNT_W-1:0] LOCK_LOAD  = CNT_W'(LOCKOUT_CYCLES);
    localparam logic [CNT_W-1:0] HALF       = CNT_W'(FLASH_HALF);

    ped_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_dec;   // crossing countdown, reused for lockout
    logic [CNT_W-1:0] half_cnt, half_cnt_n;  // cycles spent in current flash half
    logic             ped_request_q, ped_request_n;
    logic             walk_q, walk_n;
    logic             dont_walk_q, dont_walk_n;
    logic [CNT_W-1:0] countdown_q, countdown_n;
    logic             req_pending_q, req_pending_n;
    logic             fault_q, fault_n;
    logic             press, traffic_red;
    logic             unused_btn_level;
    logic             unused_yellow;

    btn_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_btn (
        .clk   (clk),
        .rst   (rst),
        .din   (bus.btn_raw),
        .level (unused_btn_level),
        .rise  (press)
    );

    // Green overrides red so a glitchy controller can't fake a safe crossing.
    assign traffic_red   = bus.light_red & ~bus.light_green;
    assign unused_yellow = bus.light_yellow;
    assign cnt_dec       = (cnt == '0) ? '0 : cnt - CNT_W'(1);

    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        half_cnt_n    = half_cnt;
        ped_request_n = 1'b0;
        walk_n        = 1'b0;
        dont_walk_n   = 1'b1;
        countdown_n   = '0;
        fault_n       = 1'b0;
        req_pending_n = req_pending_q;

        if (press && (state == IDLE || state == CLEAR || state == LOCKOUT))
            req_pending_n = 1'b1;

        case (state)
            IDLE: begin
                if (req_pending_q) begin
                    state_n       = REQUEST;
                    ped_request_n = 1'b1;
                end
            end
            REQUEST: begin
                ped_request_n = 1'b1;
                if (traffic_red) begin
                    state_n       = WALK;
                    cnt_n         = CROSS_LOAD;
                    walk_n        = 1'b1;
                    dont_walk_n   = 1'b0;
                    countdown_n   = CROSS_LOAD;
                    req_pending_n = 1'b0;
                end
            end
            WALK, FLASH: begin
                // Losing red beats any phase change; defaults give CLEAR outputs.
                if (!traffic_red) begin
                    state_n = CLEAR;
                    fault_n = 1'b1;
                end else if (state == WALK && cnt_dec > FLASH_LD) begin
                    ped_request_n = 1'b1;
                    walk_n        = 1'b1;
                    dont_walk_n   = 1'b0;
                    countdown_n   = cnt_dec;
                    cnt_n         = cnt_dec;
                end else if (cnt_dec == '0) begin
                    // end of FLASH, or end of WALK when FLASH_CYCLES is 0
                    state_n = CLEAR;
                    cnt_n   = '0;
                end else if (state == WALK) begin
                    state_n       = FLASH;
                    ped_request_n = 1'b1;
                    countdown_n   = cnt_dec;
                    cnt_n         = cnt_dec;
                    half_cnt_n    = CNT_W'(1);
                end else begin
                    ped_request_n = 1'b1;
                    countdown_n   = cnt_dec;
                    cnt_n         = cnt_dec;
                    if (half_cnt >= HALF) begin
                        dont_walk_n = ~dont_walk_q;
                        half_cnt_n  = CNT_W'(1);
                    end else begin
                        dont_walk_n = dont_walk_q;
                        half_cnt_n  = half_cnt + CNT_W'(1);
                    end
                end
            end
            CLEAR: begin
                if (bus.light_green) begin
                    state_n = LOCKOUT;
                    cnt_n   = LOCK_LOAD;
                end
            end
            LOCKOUT: begin
                // Always at least one cycle here, even with LOCKOUT_CYCLES = 0.
                if (cnt <= CNT_W'(1)) state_n = IDLE;
                else                  cnt_n   = cnt_dec;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            half_cnt      <= '0;
            ped_request_q <= 1'b0;
            walk_q        <= 1'b0;
            dont_walk_q   <= 1'b1;
            countdown_q   <= '0;
            req_pending_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            half_cnt      <= half_cnt_n;
            ped_request_q <= ped_request_n;
            walk_q        <= walk_n;
            dont_walk_q   <= dont_walk_n;
            countdown_q   <= countdown_n;
            req_pending_q <= req_pending_n;
            fault_q       <= fault_n;
        end
    end

    assign bus.ped_request = ped_request_q;
    assign bus.walk        = walk_q;
    assign bus.dont_walk   = dont_walk_q;
    assign bus.countdown   = countdown_q;
    assign bus.req_pending = req_pending_q;
    assign bus.fault       = fault_q;
endmodule

// File: tb/tb_ped_crossing_requester.sv
// Directed bench for ped_crossing_requester. Cycle numbers count clock edges
// from the start of each sequence; outputs are sampled 1 time unit after the edge.
module tb_ped_crossing_requester;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst;
    logic force_en, f_red, f_green;

    ped_crossing_requester_if #(.CNT_W(CNT_W)) bus ();

    // Traffic model: red while requested, green otherwise, unless overridden.
    assign bus.light_red    = force_en ? f_red   :  bus.ped_request;
    assign bus.light_green  = force_en ? f_green : ~bus.ped_request;
    assign bus.light_yellow = 1'b0;

    ped_crossing_requester #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int on0 = 0, off0 = 0, on1 = 0, off1 = 0;
    bit bounce = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive_btn();
        if (bounce) bus.btn_raw = (cyc < 20) && ((cyc / 2) % 2 == 0);
        else        bus.btn_raw = (cyc >= on0 && cyc < off0) || (cyc >= on1 && cyc < off1);
    endtask

    task automatic start_seq(input int a0, input int a1, input int b0, input int b1, input bit bnc);
        cyc = 0; on0 = a0; off0 = a1; on1 = b0; off1 = b1; bounce = bnc;
        drive_btn();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        drive_btn();
    endtask

    task automatic step_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ped"},   bus.ped_request, 0);
        chk({tag, "_walk"},  bus.walk,        0);
        chk({tag, "_dw"},    bus.dont_walk,   1);
        chk({tag, "_cd"},    bus.countdown,   0);
        chk({tag, "_pend"},  bus.req_pending, 0);
        chk({tag, "_fault"}, bus.fault,       0);
    endtask

    initial begin
        rst = 1'b1; force_en = 1'b0; f_red = 1'b0; f_green = 1'b0;
        start_seq(0, 0, 0, 0, 1'b0);
        step(); step();
        chk_reset("rst");
        rst = 1'b0;

        // Single press, button held 10 cycles.
        start_seq(0, 10, 0, 0, 1'b0);
        step_to(6);  chk("t1_pend_early", bus.req_pending, 0);
        step_to(7);  chk("t1_pend", bus.req_pending, 1);
                     chk("t1_ped_early", bus.ped_request, 0);
        step_to(8);  chk("t1_ped", bus.ped_request, 1);
                     chk("t1_walk_early", bus.walk, 0);
        for (int c = 9; c <= 16; c++) begin
            step_to(c);
            chk($sformatf("t1_walk[%0d]", c), bus.walk, 1);
            chk($sformatf("t1_walk_dw[%0d]", c), bus.dont_walk, 0);
            chk($sformatf("t1_walk_cd[%0d]", c), bus.countdown, 23 - c);
        end
        chk("t1_pend_clr", bus.req_pending, 0);
        for (int c = 17; c <= 22; c++) begin
            step_to(c);
            chk($sformatf("t1_fl_walk[%0d]", c), bus.walk, 0);
            chk($sformatf("t1_fl_dw[%0d]", c), bus.dont_walk, ((c - 17) / 2) % 2 == 0);
            chk($sformatf("t1_fl_cd[%0d]", c), bus.countdown, 23 - c);
            chk($sformatf("t1_fl_ped[%0d]", c), bus.ped_request, 1);
            chk($sformatf("t1_fl_fault[%0d]", c), bus.fault, 0);
        end
        step_to(23); chk("t1_clr_ped", bus.ped_request, 0);
                     chk("t1_clr_cd", bus.countdown, 0);
                     chk("t1_clr_dw", bus.dont_walk, 1);
        step_to(40); chk("t1_idle_ped", bus.ped_request, 0);
                     chk("t1_idle_pend", bus.req_pending, 0);

        // Bouncing button: toggles every 2 cycles, never stable long enough.
        start_seq(0, 0, 0, 0, 1'b1);
        for (int c = 1; c <= 40; c++) begin
            step_to(c);
            chk($sformatf("t2_pend[%0d]", c), bus.req_pending, 0);
            chk($sformatf("t2_ped[%0d]", c), bus.ped_request, 0);
        end

        // Second press lands during WALK and must be ignored.
        start_seq(0, 5, 9, 15, 1'b0);
        step_to(7);  chk("t3_pend", bus.req_pending, 1);
        step_to(9);  chk("t3_walk", bus.walk, 1);
        for (int c = 10; c <= 50; c++) begin
            step_to(c);
            chk($sformatf("t3_pend[%0d]", c), bus.req_pending, 0);
            if (c >= 23) chk($sformatf("t3_ped[%0d]", c), bus.ped_request, 0);
        end

        // Press during LOCKOUT, forwarded to a new crossing via IDLE.
        start_seq(0, 5, 19, 25, 1'b0);
        step_to(9);  chk("t4_walk", bus.walk, 1);
        step_to(25); chk("t4_pend_before", bus.req_pending, 0);
        step_to(26); chk("t4_pend_lockout", bus.req_pending, 1);
        step_to(28); chk("t4_ped_lockout", bus.ped_request, 0);
        step_to(29); chk("t4_ped_idle", bus.ped_request, 0);
                     chk("t4_pend_idle", bus.req_pending, 1);
        step_to(30); chk("t4_ped_req", bus.ped_request, 1);
        step_to(31); chk("t4_walk2", bus.walk, 1);
                     chk("t4_cd2", bus.countdown, 14);
                     chk("t4_pend_clr", bus.req_pending, 0);

        // Reset for one cycle in the middle of FLASH.
        step_to(39); chk("t5_fl_cd", bus.countdown, 6);
                     chk("t5_fl_walk", bus.walk, 0);
        step_to(40); chk("t5_fl_cd2", bus.countdown, 5);
        rst = 1'b1;
        step_to(41); chk_reset("t5_rst");
        rst = 1'b0;
        step_to(55); chk("t5_ped_after", bus.ped_request, 0);
                     chk("t5_pend_after", bus.req_pending, 0);

        // Signal lost at WALK cycle 3.
        start_seq(0, 5, 0, 0, 1'b0);
        step_to(9);  chk("t6_walk", bus.walk, 1);
        step_to(11); chk("t6_cd_pre", bus.countdown, 12);
                     chk("t6_fault_pre", bus.fault, 0);
        force_en = 1'b1; f_red = 1'b0; f_green = 1'b1;
        step_to(12); chk("t6_walk_ab", bus.walk, 0);
                     chk("t6_dw_ab", bus.dont_walk, 1);
                     chk("t6_cd_ab", bus.countdown, 0);
                     chk("t6_fault", bus.fault, 1);
                     chk("t6_ped_ab", bus.ped_request, 0);
        step_to(13); chk("t6_fault_end", bus.fault, 0);
        force_en = 1'b0;
        step_to(30); chk("t6_ped_after", bus.ped_request, 0);
                     chk("t6_pend_after", bus.req_pending, 0);
                     chk("t6_fault_after", bus.fault, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
